// File: rtl/dmem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arb_pkg
// Brief    : Shared types and constants for the data-memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package dmem_arb_pkg;

    typedef enum logic [0:0] {
        ARB_SHARED = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    typedef enum logic [0:0] {
        OWN_CPU = 1'b0,
        OWN_DBG = 1'b1
    } owner_e;

    localparam int STARVE_CNT_W = 4;

endpackage : dmem_arb_pkg
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Brief    : CPU/DBG arbiter for the single-port data memory with starvation
//            guard and DBG lock mode.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDRESS_LINE = 8,
    parameter int DATA_WIDTH   = 8,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    cpu_req,
    input  logic                    cpu_we,
    input  logic [ADDRESS_LINE-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0]   cpu_wdata,
    output logic                    cpu_gnt,
    output logic                    cpu_rvalid,
    output logic [DATA_WIDTH-1:0]   cpu_rdata,
    output logic                    cpu_stall,
    input  logic                    dbg_req,
    input  logic                    dbg_we,
    input  logic [ADDRESS_LINE-1:0] dbg_addr,
    input  logic [DATA_WIDTH-1:0]   dbg_wdata,
    input  logic                    dbg_lock,
    output logic                    dbg_gnt,
    output logic                    dbg_rvalid,
    output logic [DATA_WIDTH-1:0]   dbg_rdata,
    output logic                    dbg_locked,
    output logic                    mem_read,
    output logic                    mem_write,
    output logic [ADDRESS_LINE-1:0] mem_address,
    output logic [DATA_WIDTH-1:0]   mem_write_data,
    input  logic [DATA_WIDTH-1:0]   mem_read_data
);

    localparam logic [STARVE_CNT_W-1:0] C_STARVE_MAX = STARVE_CNT_W'(STARVE_LIMIT);

    arb_state_e              state_q;
    logic [STARVE_CNT_W-1:0] starve_q, starve_d;
    logic                    rd_pend_q, rd_pend_d;
    owner_e                  rd_own_q, rd_own_d;

    logic                    w_lock_hold;
    logic                    w_cpu_gnt;
    logic                    w_dbg_gnt;
    logic                    w_we;

    // A locked state with dbg_lock already dropped arbitrates as SHARED.
    assign w_lock_hold = (state_q == ARB_LOCKED) && dbg_lock;

    always_comb begin
        w_cpu_gnt = 1'b0;
        w_dbg_gnt = 1'b0;
        if (!reset) begin
            if (w_lock_hold) begin
                w_dbg_gnt = dbg_req;
            end else if (dbg_req && (!cpu_req || (starve_q == C_STARVE_MAX))) begin
                w_dbg_gnt = 1'b1;
            end else begin
                w_cpu_gnt = cpu_req;
            end
        end
    end

    assign w_we = w_dbg_gnt ? dbg_we : cpu_we;

    assign cpu_gnt        = w_cpu_gnt;
    assign dbg_gnt        = w_dbg_gnt;
    assign cpu_stall      = !reset && cpu_req && !w_cpu_gnt;
    assign dbg_locked     = !reset && w_lock_hold;
    assign mem_read       = (w_cpu_gnt || w_dbg_gnt) && !w_we;
    assign mem_write      = (w_cpu_gnt || w_dbg_gnt) && w_we;
    assign mem_address    = w_dbg_gnt ? dbg_addr  : (w_cpu_gnt ? cpu_addr  : '0);
    assign mem_write_data = w_dbg_gnt ? dbg_wdata : (w_cpu_gnt ? cpu_wdata : '0);

    assign cpu_rvalid = !reset && rd_pend_q && (rd_own_q == OWN_CPU);
    assign dbg_rvalid = !reset && rd_pend_q && (rd_own_q == OWN_DBG);
    assign cpu_rdata  = cpu_rvalid ? mem_read_data : '0;
    assign dbg_rdata  = dbg_rvalid ? mem_read_data : '0;

    always_comb begin
        starve_d  = '0;
        rd_pend_d = mem_read;
        rd_own_d  = w_dbg_gnt ? OWN_DBG : OWN_CPU;
        if (dbg_req && !w_dbg_gnt) begin
            starve_d = (starve_q == C_STARVE_MAX) ? starve_q : starve_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ARB_SHARED;
            starve_q  <= '0;
            rd_pend_q <= 1'b0;
            rd_own_q  <= OWN_CPU;
        end else begin
            starve_q  <= starve_d;
            rd_pend_q <= rd_pend_d;
            rd_own_q  <= rd_own_d;
            case (state_q)
                ARB_SHARED: if (w_dbg_gnt && dbg_lock) state_q <= ARB_LOCKED;
                ARB_LOCKED: if (!dbg_lock)             state_q <= ARB_SHARED;
                default:                               state_q <= ARB_SHARED;
            endcase
        end
    end

endmodule : dmem_arbiter
`default_nettype wire

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares the single-port data memory between the pipeline MEM stage (CPU port) and a debug/program-loader port (DBG port). The CPU has fixed priority, but a starvation counter guarantees the DBG port eventually gets a grant. A lock mode gives DBG exclusive ownership for bulk loads. The block sits between the MEM stage / loader and the data memory, and raises a stall to the pipeline whenever a CPU access is not granted.

Parameters:
ADDRESS_LINE, 8, address width of the data memory
DATA_WIDTH, 8, data width of the data memory
STARVE_LIMIT, 4, consecutive denied DBG-request cycles before DBG is forced the next grant (range 1..15)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
cpu_req  in  1  CPU access request (MEM stage mem_read|mem_write)
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  ADDRESS_LINE  CPU address (ALU result)
cpu_wdata  in  DATA_WIDTH  CPU store data
cpu_gnt  out  1  CPU access issued this cycle
cpu_rvalid  out  1  CPU read data valid
cpu_rdata  out  DATA_WIDTH  CPU read data
cpu_stall  out  1  freeze the pipeline: cpu_req & ~cpu_gnt
dbg_req  in  1  DBG access request
dbg_we  in  1  1 = write, 0 = read
dbg_addr  in  ADDRESS_LINE  DBG address
dbg_wdata  in  DATA_WIDTH  DBG write data
dbg_lock  in  1  request exclusive DBG ownership
dbg_gnt  out  1  DBG access issued this cycle
dbg_rvalid  out  1  DBG read data valid
dbg_rdata  out  DATA_WIDTH  DBG read data
dbg_locked  out  1  DBG currently owns memory exclusively
mem_read  out  1  to data memory
mem_write  out  1  to data memory
mem_address  out  ADDRESS_LINE  to data memory
mem_write_data  out  DATA_WIDTH  to data memory
mem_read_data  in  DATA_WIDTH  from data memory; valid the cycle after mem_read

Behaviour:
- Handshake: requester holds req/we/addr/wdata stable until it sees gnt. gnt is combinational in the cycle the access issues. One access per cycle total.
- Issue cycle N: mem_read = ~we, mem_write = we, mem_address/mem_write_data come from the granted port. If neither port is granted, all mem_* outputs are 0.
- Reads: granted port's rvalid = 1 in cycle N+1 with rdata = mem_read_data. A one-bit registered owner tag steers the data. Writes produce no rvalid.
- rdata for the non-valid port is 0.
- State machine, SHARED (reset state):
  - only one req active -> grant it;
  - both active -> CPU wins, unless starve_cnt == STARVE_LIMIT, then DBG wins.
- starve_cnt:
  - increments each cycle dbg_req=1 and dbg_gnt=0;
  - clears on dbg_gnt or when dbg_req=0;
  - saturates at STARVE_LIMIT.
- SHARED -> LOCKED: on a cycle where dbg_gnt=1 and dbg_lock=1.
- LOCKED behaviour:
  - dbg_locked=1 and cpu_gnt=0; any cpu_req stalls;
  - DBG is granted whenever dbg_req=1.
- LOCKED -> SHARED: in the first cycle dbg_lock=0, and that cycle already uses SHARED arbitration.
- Simultaneous events: a read issued in the cycle the state changes still returns rvalid on its original port.
- Reset:
  - all outputs 0, state SHARED, starve_cnt 0;
  - a pending read tag is discarded, so no rvalid in the cycle after reset.

Decomposition:
- Shared package dmem_arb_pkg:
  - state encoding (ARB_SHARED, ARB_LOCKED);
  - owner encoding (OWN_CPU=0, OWN_DBG=1);
  - starve counter width constant (4 bits).
- Single flat module; no sub-module is warranted.

Test Plan:
- CPU read addr 8'h10, memory holds 8'hA5 -> cpu_gnt=1 cycle N, mem_read=1, mem_address=8'h10; cycle N+1 cpu_rvalid=1, cpu_rdata=8'hA5, dbg_rvalid=0.
- Both requesters held continuously (CPU read 8'h20, DBG write 8'h30/8'h5A), STARVE_LIMIT=4 -> CPU granted cycles 0..3; cycle 4 dbg_gnt=1, mem_write=1, cpu_stall=1; cycle 5 CPU granted again.
- DBG write with dbg_lock=1 -> dbg_locked=1 from next cycle. CPU req during lock -> cpu_stall=1, cpu_gnt=0. Drop dbg_lock -> same cycle cpu_gnt=1, dbg_locked=0.
- DBG read 8'h40 issued in the last locked cycle, CPU granted next -> dbg_rvalid=1 next cycle with the 8'h40 data, cpu_rvalid=0.
- CPU read granted, reset asserted next cycle -> cpu_rvalid=0, all mem_* and gnt outputs 0, state SHARED, starve_cnt 0.
- No requests -> mem_read=mem_write=0, mem_address=0, cpu_stall=0; starve_cnt stays 0.
